// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file constants and writeback source ids.
// Used by the writeback arbiter and by any block that sizes
// register-file indices or data.
package rf_writeback_arbiter_pkg;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 2 ** RF_ADDR_W;

  // Writeback sources, in requester-slot order.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wb_src_e;

  localparam int unsigned WB_NUM_SRC = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant selection.
// The search starts one slot past the last winner (ptr), so the most
// recent winner has the lowest priority next time.
// Ports:
//   req    in  N     requesting slots
//   ptr    in  IdxW  index of the previous winner
//   grant  out N     one-hot grant, or all zero when no request
//   winner out IdxW  index of the granted slot (0 when no grant)
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] winner
);

  always_comb begin
    logic        found;
    int unsigned idx;
    found  = 1'b0;
    idx    = 0;
    grant  = '0;
    winner = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter.
// Each writeback source owns a one-entry holding buffer (valid/ready). A
// round-robin arbiter drains the buffers onto a single registered write port.
// pend_mask flags every register with a write buffered or on the port so
// decode can stall on RAW hazards.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req_valid  per-requester write offer
//   req_ready  per-requester buffer can accept this cycle
//   req_addr   packed destination indices, slice i = requester i
//   req_data   packed write data, slice i = requester i
//   wr_stall   hold all grants
//   wr_en      register-file write enable (registered)
//   wr_addr    register-file write index (registered)
//   wr_data    register-file write data (registered)
//   pend_mask  bit r set: write to register r is outstanding
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = WB_NUM_SRC,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2**ADDR_W-1:0]      pend_mask
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_v_q;
  logic [ADDR_W-1:0]  buf_addr_q [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
  logic [PtrW-1:0]    rr_ptr_q;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    winner;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic               drop_zero;

  assign cand = buf_v_q & ~{NUM_REQ{wr_stall}};

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req    (cand),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  assign win_addr  = buf_addr_q[winner];
  assign win_data  = buf_data_q[winner];
  assign drop_zero = ZERO_REG && (win_addr == '0);

  // A buffer being drained this cycle can take a new write at the same edge.
  assign req_ready = rst ? '0 : (~buf_v_q | grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q  <= '0;
      rr_ptr_q <= PtrW'(NUM_REQ - 1);
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_v_q[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_v_q[i] <= 1'b0;
        end
      end
      if (|grant) begin
        // Register-0 writes still take the grant and the round-robin turn.
        rr_ptr_q <= winner;
        wr_en    <= !drop_zero;
        wr_addr  <= win_addr;
        wr_data  <= win_data;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && req_ready[i]) begin
        buf_addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
        buf_data_q[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (buf_v_q[i]) begin
        pend_mask[buf_addr_q[i]] = 1'b1;
      end
    end
    if (wr_en) begin
      pend_mask[wr_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      pend_mask[0] = 1'b0;
    end
  end

endmodule
